fifo_rd_ctrl: RTL
=================

// Module: fifo_rd_ctrl
// PURPOSE
//  Read-side controller for async_fifo. Lives entirely in the read clock domain.
//  Synchronises the write pointer with an internal cdc_dff instance and computes empty and level.
//  Sequences reads of the registered-output dual-port RAM and presents them as a first-word-fall-through (FWFT) stream.
//  Exports the Gray-coded read pointer to the write domain.
// PARAMETERS
//  ADDR_WIDTH           4  RAM address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//  NUM_SYNC_STAGES      2  cdc_dff depth for the write pointer (0 allowed = no sync, no warm-up)
//  ALMOST_EMPTY_THRESH  2  almost_empty asserted when rd_level <= this value
// PORTS
//  clk               in   1     read-domain clock
//  rst_n             in   1     asynchronous active-low reset
//  wr_ptr_gray_async in   A+1   Gray write pointer from the write domain (unsynchronised)
//  rd_en             in   1     pop request; a pop occurs only when rd_en & dout_valid
//  mem_ren           out  1     RAM read enable (combinational)
//  rd_addr           out  A     RAM read address = rd_ptr_bin[A-1:0]
//  mem_rdata         in   DW    RAM read data, valid one clk after mem_ren
//  dout              out  DW    FWFT head word (DW = fixed parameter DATA_WIDTH, default 8)
//  dout_valid        out  1     dout holds a valid word
//  rd_ptr_gray       out  A+1   registered Gray read pointer to the write domain
//  empty             out  1     = ~dout_valid
//  almost_empty      out  1     rd_level <= ALMOST_EMPTY_THRESH
//  rd_level          out  A+2   words held in RAM + in flight + output stage
//  underflow         out  1     1-clk registered pulse on rd_en & ~dout_valid
// BEHAVIOUR
//  Reset (async, rst_n=0): rd_ptr_bin=0, rd_ptr_gray=0, dout=0, dout_valid=0, skid empty,
//   inflight=0, underflow=0, warm-up counter=0. Derived outputs during reset:
//   mem_ren=0, empty=1, rd_level=0. Reset mid-operation discards in-flight and buffered
//   words; the write domain is reset at system level in the same event.
//  Warm-up: for NUM_SYNC_STAGES clks after reset release, mem_empty is forced to 1. This masks
//   unreset cdc_dff contents.
//  wr_ptr_bin = gray2bin(sync output). mem_empty = warmup | (bin2gray(rd_ptr_bin) == wr_sync).
//  Output stage: dout register plus one skid register. out_cnt is 0..2. inflight is 1 bit.
//  pop = rd_en & dout_valid.
//  mem_ren = ~mem_empty & ((out_cnt - pop + inflight) <= 1). There is no other gating.
//  On mem_ren: rd_ptr_bin increments at the clk edge, and rd_ptr_gray updates at the same edge.
//   The RAM slot is released to the writer at that edge. inflight is set for the next clk.
//  Arrival (inflight=1): mem_rdata is captured into dout if dout is free after this clk's pop.
//   Otherwise it is captured into the skid. On pop, the skid moves to dout in the same edge.
//  Ordering is strict FIFO. There is no word loss or duplication, including pop+arrival in the same clk.
//  Latency: first word visible (dout_valid=1) two clks after mem_ren. Sustained throughput is 1 word/clk.
//  rd_level = ((wr_ptr_bin - rd_ptr_bin) mod 2**(A+1)) + inflight + out_cnt, combinational.
//   During warm-up the RAM term is forced to 0.
//  Wrap: pointers roll over naturally at 2**(A+1). rd_addr wraps from 2**A-1 to 0.
//   rd_ptr_gray changes by exactly one bit per increment.
//  Underflow: rd_en=1 with dout_valid=0 sets underflow=1 for the next clk only.
//   No pointer or data change results.
// TESTING
//  T1 warm-up: release rst_n with wr_ptr_gray_async=5'b00011 (2 words)
//   -> mem_ren=0 for the first 2 clks; dout_valid rises no earlier than clk 4; dout=word0.
//  T2 stream: 16 words preloaded, rd_en held at 1
//   -> 16 pops on 16 consecutive clks once dout_valid=1; data in order; empty=1 afterward.
//  T3 backpressure: 5 words, rd_en=0
//   -> exactly 2 mem_ren pulses, then mem_ren=0; out_cnt=2; rd_level=5; almost_empty=0.
//  T4 wrap: A=4, 40 words written and read
//   -> rd_addr wraps 15->0 twice; every rd_ptr_gray step is single-bit; no data loss.
//  T5 underflow: empty FIFO, rd_en pulse for 1 clk
//   -> underflow=1 for exactly 1 clk; rd_ptr_gray and dout unchanged.
//  T6 reset mid-stream: rst_n=0 while inflight=1 and out_cnt=2
//   -> dout_valid=0, rd_ptr_gray=0, rd_level=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl -- read-side controller of async_fifo (read clock domain only)
//
// Synchronises the Gray write pointer from the write domain, works out empty
// and fill level, and sequences reads of a registered-output dual-port RAM.
// The RAM words are presented as a first-word-fall-through stream through a
// two-entry output stage (dout register plus one skid register). The Gray read
// pointer is exported to the write domain.
//
// Ports
//   clk                read-domain clock
//   rst_n              asynchronous active-low reset
//   wr_ptr_gray_async  Gray write pointer from the write domain (unsynchronised)
//   rd_en              pop request; a pop happens only when dout_valid is high
//   mem_ren            RAM read enable (combinational)
//   rd_addr            RAM read address
//   mem_rdata          RAM read data, valid one clk after mem_ren
//   dout               FWFT head word
//   dout_valid         dout holds a valid word
//   rd_ptr_gray        registered Gray read pointer to the write domain
//   empty              no word available at dout
//   almost_empty       rd_level <= ALMOST_EMPTY_THRESH
//   rd_level           words in RAM + in flight + in the output stage
//   underflow          one-clk pulse after a pop request with nothing to pop
// -----------------------------------------------------------------------------

// Multi-stage synchroniser for a bus that changes at most one bit at a time.
// STAGES = 0 degenerates to a plain wire.
module cdc_dff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    assign q = d;
  end else begin : g_chain
    logic [WIDTH-1:0] chain [STAGES];

    // NOTE: the synchroniser flops are deliberately left without reset; their
    // power-up contents are masked by the warm-up window in the user.
    always_ff @(posedge clk) begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end

    assign q = chain[STAGES-1];
  end

endmodule

module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH          = 4,
  parameter int DATA_WIDTH          = 8,
  parameter int NUM_SYNC_STAGES     = 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_async,
  input  logic                  rd_en,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH+1:0] rd_level,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;  // pointer width (one wrap bit)
  localparam int LW = ADDR_WIDTH + 2;  // level width

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Write pointer synchronisation and warm-up
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wr_sync;
  logic [PW-1:0] wr_bin;
  logic          warmup;

  cdc_dff #(
    .WIDTH  (PW),
    .STAGES (NUM_SYNC_STAGES)
  ) u_wr_sync (
    .clk (clk),
    .d   (wr_ptr_gray_async),
    .q   (wr_sync)
  );

  assign wr_bin = gray2bin(wr_sync);

  if (NUM_SYNC_STAGES > 0) begin : g_warm
    localparam int CW = $clog2(NUM_SYNC_STAGES + 1);
    logic [CW-1:0] warm_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        warm_cnt <= '0;
      end else if (warm_cnt != CW'(NUM_SYNC_STAGES)) begin
        warm_cnt <= warm_cnt + CW'(1);
      end
    end

    assign warmup = (warm_cnt != CW'(NUM_SYNC_STAGES));
  end else begin : g_no_warm
    assign warmup = 1'b0;
  end

  // While in reset or warming up the synchronised pointer is not trusted:
  // treat the RAM as empty and report no RAM words in the level.
  logic hold;
  assign hold = ~rst_n | warmup;

  // ---------------------------------------------------------------------------
  // Read pointer and RAM read sequencing
  // ---------------------------------------------------------------------------
  logic [PW-1:0]         rd_ptr_bin;
  logic                  inflight;
  logic                  mem_empty;
  logic                  pop;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid;
  logic [1:0]            out_cnt;
  logic [2:0]            ren_budget;

  assign pop       = rd_en & dout_valid;
  assign out_cnt   = {1'b0, dout_valid} + {1'b0, skid_valid};
  assign mem_empty = hold | (rd_ptr_gray == wr_sync);

  // Words that will occupy the output stage once this clk's pop and arrival
  // settle; a new read is issued only if its data is sure to find a slot.
  assign ren_budget = 3'(out_cnt) - 3'(pop) + 3'(inflight);
  assign mem_ren    = ~mem_empty & (ren_budget <= 3'd1);
  assign rd_addr    = rd_ptr_bin[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_bin  <= '0;
      rd_ptr_gray <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= mem_ren;
      if (mem_ren) begin
        rd_ptr_bin  <= rd_ptr_bin + PW'(1);
        rd_ptr_gray <= bin2gray(rd_ptr_bin + PW'(1));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: dout register + skid register
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] dout_nxt;
  logic [DATA_WIDTH-1:0] skid_nxt;
  logic                  dout_valid_nxt;
  logic                  skid_valid_nxt;

  // NOTE: every output of this block is given a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    dout_nxt       = dout;
    skid_nxt       = skid;
    dout_valid_nxt = dout_valid;
    skid_valid_nxt = skid_valid;

    // Pop first: the skid word (older) advances into dout.
    if (pop) begin
      if (skid_valid) begin
        dout_nxt       = skid;
        skid_valid_nxt = 1'b0;
      end else begin
        dout_valid_nxt = 1'b0;
      end
    end

    // Then the arriving RAM word takes the first free slot behind it.
    if (inflight) begin
      if (!dout_valid_nxt) begin
        dout_nxt       = mem_rdata;
        dout_valid_nxt = 1'b1;
      end else begin
        skid_nxt       = mem_rdata;
        skid_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      skid       <= '0;
      dout_valid <= 1'b0;
      skid_valid <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dout       <= dout_nxt;
      skid       <= skid_nxt;
      dout_valid <= dout_valid_nxt;
      skid_valid <= skid_valid_nxt;
      underflow  <= rd_en & ~dout_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  logic [PW-1:0] ram_words;

  assign ram_words    = hold ? '0 : (wr_bin - rd_ptr_bin);
  assign rd_level     = LW'(ram_words) + LW'(inflight) + LW'(out_cnt);
  assign empty        = ~dout_valid;
  assign almost_empty = (rd_level <= LW'(ALMOST_EMPTY_THRESH));

endmodule
